// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-channel, W-bit registered multiplexer with per-channel
// valid/ready handshake and selectable arbitration.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mode[1:0]         00 round-robin, 01 fixed priority (ch0 highest),
//                     10 manual select via sel, 11 behaves as 00
//   sel[SEL_W-1:0]    channel index for manual mode
//   in_data           flat bus, channel i at [i*WIDTH +: WIDTH]
//   in_valid/in_ready per-channel handshake (in_ready is combinational)
//   out_data/out_valid/out_sel  registered output word, valid, source index
//   out_ready         downstream ready
//   xfer_cnt[15:0]    output handshake counter, present only when the
//                     RR_MUX_XFER_CNT_EN macro is defined
module rr_mux_arb #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
`ifdef RR_MUX_XFER_CNT_EN
  ,
  output logic [15:0]             xfer_cnt
`endif
);

  logic [SEL_W-1:0]  rr_ptr;
  logic              load;
  logic              gnt_any;
  logic [SEL_W-1:0]  gnt_idx;
  logic [WIDTH-1:0]  gnt_data;
  logic [NUM_CH-1:0] grant;
  logic              rr_mode;
  logic [SEL_W-1:0]  rr_next;

  assign load    = ~out_valid | out_ready;
  assign rr_mode = (mode != 2'b01) && (mode != 2'b10);

  // Grant is reduced to an index plus an any-flag; the one-hot vector is
  // rebuilt from those so in_ready can never have more than one bit set.
  always_comb begin
    int unsigned idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (mode == 2'b10) begin
      if ((int'(sel) < NUM_CH) && in_valid[sel]) begin
        gnt_any = 1'b1;
        gnt_idx = sel;
      end
    end else if (mode == 2'b01) begin
      for (int unsigned k = NUM_CH; k > 0; k--) begin
        if (in_valid[k-1]) begin
          gnt_any = 1'b1;
          gnt_idx = SEL_W'(k-1);
        end
      end
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_CH;
        if (!gnt_any && in_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    grant    = '0;
    gnt_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt_any && (SEL_W'(i) == gnt_idx)) begin
        grant[i] = 1'b1;
        gnt_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = grant & {NUM_CH{load & ~rst}};

  assign rr_next = (gnt_idx == SEL_W'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (gnt_any) begin
        out_data  <= gnt_data;
        out_sel   <= gnt_idx;
        out_valid <= 1'b1;
        if (rr_mode)
          rr_ptr <= rr_next;
      end else begin
        // Bubble: data and index keep their last values.
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RR_MUX_XFER_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      xfer_cnt <= '0;
    else if (out_valid && out_ready)
      xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_rr_mux_arb.sv
module tb_rr_mux_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   mode;
  logic [1:0]   sel;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic [1:0]   out_sel;
  logic         out_ready;
`ifdef RR_MUX_XFER_CNT_EN
  logic [15:0]  xfer_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rr_mux_arb #(.NUM_CH(4), .WIDTH(32)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sel(out_sel),
    .out_ready(out_ready)
`ifdef RR_MUX_XFER_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
    in_data[0*32 +: 32] = d0;
    in_data[1*32 +: 32] = d1;
    in_data[2*32 +: 32] = d2;
    in_data[3*32 +: 32] = d3;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'b00; sel = 2'd0; out_ready = 1'b1;
    in_valid = 4'b1111;
    set_data(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    for (int c = 0; c < 2; c++) begin
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", out_data); end
      tests++; if (out_sel !== 2'd0) begin fails++; $display("FAIL reset_sel: got %0d expected 0", out_sel); end
      tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_sel;
    mode = 2'b00; in_valid = 4'b1111; out_ready = 1'b1;
    set_data(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    #1;
    tests++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL rr_first_ready: got %b expected 0001", in_ready); end
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_sel = 2'(k % 4);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rr_valid[%0d]: got %b expected 1", k, out_valid); end
      tests++; if (out_sel !== exp_sel) begin fails++; $display("FAIL rr_sel[%0d]: got %0d expected %0d", k, out_sel, exp_sel); end
      tests++; if (out_data !== 32'hA0 + 32'(exp_sel)) begin fails++; $display("FAIL rr_data[%0d]: got %h expected %h", k, out_data, 32'hA0 + 32'(exp_sel)); end
    end
    // Bubble: nothing valid, output drains and holds last data/index.
    in_valid = 4'b0000;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bubble_valid: got %b expected 0", out_valid); end
    tests++; if (out_data !== 32'hA0) begin fails++; $display("FAIL bubble_data_hold: got %h expected a0", out_data); end
    tests++; if (out_sel !== 2'd0) begin fails++; $display("FAIL bubble_sel_hold: got %0d expected 0", out_sel); end
  endtask

  task automatic test_fixed_priority();
    mode = 2'b01; in_valid = 4'b1010;
    set_data(32'h00, 32'h11, 32'h22, 32'h33);
    #1;
    tests++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL fp_ready_idle: got %b expected 0010", in_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if (out_sel !== 2'd1) begin fails++; $display("FAIL fp_sel[%0d]: got %0d expected 1", k, out_sel); end
      tests++; if (out_data !== 32'h11) begin fails++; $display("FAIL fp_data[%0d]: got %h expected 11", k, out_data); end
      tests++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL fp_ready[%0d]: got %b expected 0010", k, in_ready); end
    end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_manual();
    mode = 2'b10; sel = 2'd2; in_valid = 4'b1111;
    set_data(32'h0, 32'h1, 32'h0, 32'h1);
    #1;
    tests++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL man_ready2: got %b expected 0100", in_ready); end
    tick();
    tests++; if (out_data !== 32'h0 || out_sel !== 2'd2) begin fails++; $display("FAIL man_sel2: got data %h sel %0d expected 0 sel 2", out_data, out_sel); end
    sel = 2'd3;
    #1;
    tests++; if (in_ready !== 4'b1000) begin fails++; $display("FAIL man_ready3: got %b expected 1000", in_ready); end
    tick();
    tests++; if (out_data !== 32'h1 || out_sel !== 2'd3) begin fails++; $display("FAIL man_sel3: got data %h sel %0d expected 1 sel 3", out_data, out_sel); end
    // Selected channel not valid: no grant even though others are valid.
    in_valid = 4'b0111;
    #1;
    tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL man_nogrant_ready: got %b expected 0000", in_ready); end
    tick();
    tests++; if (out_valid !== 1'b0 || out_sel !== 2'd3) begin fails++; $display("FAIL man_nogrant: got valid %b sel %0d expected 0 sel 3", out_valid, out_sel); end
  endtask

  task automatic test_back_to_back();
    // rr_ptr is 1 here: last round-robin transfer was ch0; modes 01/10 held it.
    mode = 2'b00; in_valid = 4'b1111; out_ready = 1'b0;
    set_data(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    #1;
    tests++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL bp_first_ready: got %b expected 0010", in_ready); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 32'hA1) begin fails++; $display("FAIL bp_load: got v%b sel %0d data %h expected v1 sel 1 a1", out_valid, out_sel, out_data); end
    for (int k = 0; k < 3; k++) begin
      tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready[%0d]: got %b expected 0000", k, in_ready); end
      tick();
      tests++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 32'hA1) begin fails++; $display("FAIL bp_hold[%0d]: got v%b sel %0d data %h expected v1 sel 1 a1", k, out_valid, out_sel, out_data); end
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL bp_release_ready: got %b expected 0100", in_ready); end
    tick();
    tests++; if (out_sel !== 2'd2 || out_data !== 32'hA2) begin fails++; $display("FAIL bp_release: got sel %0d data %h expected 2 a2", out_sel, out_data); end
    // Reserved mode behaves as round-robin.
    mode = 2'b11;
    tick();
    tests++; if (out_sel !== 2'd3 || out_data !== 32'hA3) begin fails++; $display("FAIL mode11_a: got sel %0d data %h expected 3 a3", out_sel, out_data); end
    tick();
    tests++; if (out_sel !== 2'd0 || out_data !== 32'hA0) begin fails++; $display("FAIL mode11_wrap: got sel %0d data %h expected 0 a0", out_sel, out_data); end
    // Reset mid-stream discards the word and returns rr_ptr to 0 (it was 1).
    rst = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin fails++; $display("FAIL midrst: got v%b data %h expected v0 0", out_valid, out_data); end
    rst = 1'b0; mode = 2'b00;
    #1;
    tests++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL midrst_ptr: got %b expected 0001", in_ready); end
  endtask

`ifdef RR_MUX_XFER_CNT_EN
  task automatic test_xfer_cnt();
    rst = 1'b1; mode = 2'b01; in_valid = 4'b0001; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (xfer_cnt !== 16'd0) begin fails++; $display("FAIL cnt_reset: got %0d expected 0", xfer_cnt); end
    for (int k = 0; k < 6; k++) tick();
    tests++; if (xfer_cnt !== 16'd5) begin fails++; $display("FAIL cnt_five: got %0d expected 5", xfer_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (xfer_cnt !== 16'd0) begin fails++; $display("FAIL cnt_rst: got %0d expected 0", xfer_cnt); end
    for (int k = 0; k < 65536; k++) tick();
    tests++; if (xfer_cnt !== 16'hFFFF) begin fails++; $display("FAIL cnt_max: got %h expected ffff", xfer_cnt); end
    tick();
    tests++; if (xfer_cnt !== 16'h0000) begin fails++; $display("FAIL cnt_wrap: got %h expected 0000", xfer_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_manual();
    test_back_to_back();
`ifdef RR_MUX_XFER_CNT_EN
    test_xfer_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised successor to the team's 4:1 word multiplexer: N-channel, W-bit, registered multiplexer with per-channel valid/ready handshake and selectable arbitration mode.
- Sits between several producer channels and a single downstream consumer.
- Supports round-robin, fixed-priority and manual-select modes; manual select reproduces the legacy sel-driven mux behaviour.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- WIDTH, 32, data width per channel.
- SEL_W, $clog2(NUM_CH), width of select/index fields (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- mode  input  2  00 round-robin, 01 fixed priority (ch0 highest), 10 manual select, 11 reserved (treated as 00).
- sel  input  SEL_W  channel index used in manual mode.
- in_data  input  NUM_CH*WIDTH  flat bus; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready (combinational).
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  registered valid.
- out_sel  output  SEL_W  index of channel that supplied out_data.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_sel=0, rr_ptr=0. in_ready is 0 while rst=1.
- load = ~out_valid | out_ready. The output register accepts a new word only when load=1.
- Grant is combinational, one-hot or zero:
  - mode 00: first valid channel searching from rr_ptr upward, wrapping NUM_CH-1 -> 0.
  - mode 01: lowest-index valid channel.
  - mode 10: channel sel if in_valid[sel]; otherwise no grant. A sel value >= NUM_CH means no grant.
- in_ready[i] = grant[i] & load & ~rst. A transfer on channel i occurs when in_valid[i] & in_ready[i].
- On a transfer: out_data <= channel data, out_sel <= i, out_valid <= 1. Latency is 1 cycle from input handshake to out_valid.
- No grant and load=1: out_valid <= 0 after the next edge (bubble). out_data and out_sel hold their last values.
- out_valid=1 with out_ready=0: out_data, out_valid and out_sel hold stable; all in_ready are 0.
- Simultaneous drain and fill (out_valid=1, out_ready=1, grant present): new word is loaded in the same cycle, giving full throughput of 1 word/cycle.
- rr_ptr updates only on a transfer in mode 00: rr_ptr <= i+1, wrapping to 0 after NUM_CH-1. In modes 01 and 10 rr_ptr holds.
- Mode or sel changes take effect on the next grant evaluation. A word already in the output register is unaffected.
- Reset mid-transfer: the pending output word is discarded; out_valid=0 on the following cycle.
- Producers must hold data stable while valid and not ready; the block does not check this.

Optional Feature:
- Macro RR_MUX_XFER_CNT_EN.
- Defined: adds output port xfer_cnt [15:0]. It increments by 1 on each output handshake (out_valid & out_ready), wraps 0xFFFF -> 0, and resets to 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0000 throughout.
- Round-robin fairness: mode=00, all 4 channels valid with data 0xA0..0xA3, out_ready=1 -> out_sel sequence 0,1,2,3,0; out_valid continuously 1 after first edge.
- Fixed priority: mode=01, in_valid=1010, out_ready=1 -> ch1 (data 0x11) granted every cycle; in_ready=0010; ch3 starved.
- Manual select: mode=10, sel=2, in_valid=1111, data in1..in4 = 0,1,0,1 -> out_data=0 and out_sel=2. Then sel=3 -> out_data=1 and out_sel=3 one cycle later.
- Backpressure: mode=00, out_ready=0 for 3 cycles after first load -> out_data stable, in_ready=0000. Release out_ready -> next channel (rr_ptr) is loaded on the same edge as the drain.
- With RR_MUX_XFER_CNT_EN: 5 handshakes then rst -> xfer_cnt reads 5, then 0. Preload to 0xFFFF via 65535 transfers plus 1 more -> xfer_cnt=0.
